// File: rtl/raytracer_axis_pkg.sv
// Shared types, defaults and the dummy
// output pattern for the raytracer AXIS front end.
package raytracer_axis_pkg;

  typedef enum logic [1:0] {
    RECV  = 2'd0,
    DRAIN = 2'd1,
    EMIT  = 2'd2
  } state_e;

  localparam int          DEF_DATA_W       = 32;
  localparam int          DEF_SCENE_WORDS  = 16;
  localparam int          DEF_FRAG_WORDS   = 64;
  localparam int          DEF_NUM_FRAGS    = 4;
  localparam logic [63:0] DEF_DUMMY        = 64'hDEAD_0000;
  localparam bit          DEF_TLAST_PER_FR = 1'b1;

  // Dummy fragment word; caller truncates to its data width.
  function automatic logic [63:0] pattern_word(
    input logic [63:0] base,
    input logic [63:0] k
  );
    return base + k;
  endfunction

endpackage

// File: rtl/raytracer_axis_scene_regs.sv
// Scene register file: one write port, one
// combinational read port; out-of-range reads give 0.
module raytracer_axis_scene_regs
  import raytracer_axis_pkg::*;
#(
  parameter int  DataWidth = DEF_DATA_W,
  parameter int  Depth     = DEF_SCENE_WORDS,
  localparam int AW        = $clog2(Depth)
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [AW-1:0]        waddr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [AW-1:0]        raddr_i,
  output logic [DataWidth-1:0] rdata_o
);

  logic [DataWidth-1:0] mem_q [Depth];

  // Storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Mux over valid entries only, so unused addresses read 0.
  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < Depth; i++) begin
      if (raddr_i == AW'(i)) begin
        rdata_o = mem_q[i];
      end
    end
  end

endmodule

// File: rtl/raytracer_axis_stream.sv
// Raytracer AXIS front end: receive a scene frame,
// check its length, then stream dummy fragments.
module raytracer_axis_stream
  import raytracer_axis_pkg::*;
#(
  parameter int          DataWidth        = DEF_DATA_W,
  parameter int          ScenePayloadSize = DEF_SCENE_WORDS,
  parameter int          FragmentSize     = DEF_FRAG_WORDS,
  parameter int          NumFragments     = DEF_NUM_FRAGS,
  parameter logic [63:0] DummyData        = DEF_DUMMY,
  parameter bit          TlastPerFragment = DEF_TLAST_PER_FR,
  localparam int         AW = $clog2(ScenePayloadSize)
) (
  input  logic                 aclk,
  input  logic                 areset,
  output logic                 s_axis_tready,
  input  logic [DataWidth-1:0] s_axis_tdata,
  input  logic                 s_axis_tlast,
  input  logic                 s_axis_tvalid,
  output logic                 m_axis_tvalid,
  output logic [DataWidth-1:0] m_axis_tdata,
  output logic                 m_axis_tlast,
  input  logic                 m_axis_tready,
  input  logic [AW-1:0]        scene_rd_addr,
  output logic [DataWidth-1:0] scene_rd_data,
  output logic                 frame_done,
  output logic                 err_short,
  output logic                 err_long
);

  localparam int Total = NumFragments * FragmentSize;
  localparam int KW = (Total > 1) ? $clog2(Total) : 1;
  localparam int FW = (FragmentSize > 1) ? $clog2(FragmentSize) : 1;

  localparam logic [AW-1:0] LastIn = AW'(ScenePayloadSize - 1);
  localparam logic [KW-1:0] LastK  = KW'(Total - 1);
  localparam logic [FW-1:0] LastF  = FW'(FragmentSize - 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   in_cnt_q, in_cnt_d;
  logic [KW-1:0]   k_q, k_d;
  logic [FW-1:0]   f_q, f_d;
  logic            done_q, done_d;
  logic            es_q, es_d;
  logic            el_q, el_d;
  logic            s_beat, m_beat, we;

  raytracer_axis_scene_regs #(
    .DataWidth (DataWidth),
    .Depth     (ScenePayloadSize)
  ) u_regs (
    .clk_i   (aclk),
    .we_i    (we),
    .waddr_i (in_cnt_q),
    .wdata_i (s_axis_tdata),
    .raddr_i (scene_rd_addr),
    .rdata_o (scene_rd_data)
  );

  // State, counters and one-cycle status pulses.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q  <= RECV;
      in_cnt_q <= '0;
      k_q      <= '0;
      f_q      <= '0;
      done_q   <= 1'b0;
      es_q     <= 1'b0;
      el_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_cnt_q <= in_cnt_d;
      k_q      <= k_d;
      f_q      <= f_d;
      done_q   <= done_d;
      es_q     <= es_d;
      el_q     <= el_d;
    end
  end

  // Handshakes, length checks and fragment sequencing.
  always_comb begin
    state_d  = state_q;
    in_cnt_d = in_cnt_q;
    k_d      = k_q;
    f_d      = f_q;
    done_d   = 1'b0;
    es_d     = 1'b0;
    el_d     = 1'b0;
    we       = 1'b0;

    s_axis_tready = !areset && (state_q != EMIT);
    m_axis_tvalid = (state_q == EMIT);
    s_beat = s_axis_tvalid && s_axis_tready;
    m_beat = m_axis_tvalid && m_axis_tready;

    unique case (state_q)
      RECV: begin
        if (s_beat) begin
          we = 1'b1;
          if (in_cnt_q == LastIn) begin
            in_cnt_d = '0;
            if (s_axis_tlast) begin
              state_d = EMIT;
              k_d     = '0;
              f_d     = '0;
            end else begin
              el_d    = 1'b1;
              state_d = DRAIN;
            end
          end else if (s_axis_tlast) begin
            es_d     = 1'b1;
            in_cnt_d = '0;
          end else begin
            in_cnt_d = in_cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (s_beat && s_axis_tlast) begin
          state_d  = RECV;
          in_cnt_d = '0;
        end
      end
      EMIT: begin
        if (m_beat) begin
          if (k_q == LastK) begin
            state_d = RECV;
            done_d  = 1'b1;
          end else begin
            k_d = k_q + 1'b1;
            f_d = (f_q == LastF) ? '0 : f_q + 1'b1;
          end
        end
      end
      default: state_d = RECV;
    endcase
  end

  // Output word and end marker derive from the current index.
  always_comb begin
    m_axis_tdata = '0;
    m_axis_tlast = 1'b0;
    if (state_q == EMIT) begin
      m_axis_tdata = DataWidth'(pattern_word(DummyData, 64'(k_q)));
      m_axis_tlast = TlastPerFragment ? (f_q == LastF)
                                      : (k_q == LastK);
    end
  end

  assign frame_done = done_q;
  assign err_short  = es_q;
  assign err_long   = el_q;

endmodule

// File: tb/tb_raytracer_axis_stream.sv
// Self-checking bench for raytracer_axis_stream:
// default instance plus an 8-bit single-tlast instance.
module tb_raytracer_axis_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic        a_s_tready, a_s_tlast, a_s_tvalid;
  logic [31:0] a_s_tdata;
  logic        a_m_tvalid, a_m_tlast, a_m_tready;
  logic [31:0] a_m_tdata;
  logic [3:0]  a_rd_addr;
  logic [31:0] a_rd_data;
  logic        a_done, a_es, a_el;

  logic        b_s_tready, b_s_tlast, b_s_tvalid;
  logic [7:0]  b_s_tdata;
  logic        b_m_tvalid, b_m_tlast, b_m_tready;
  logic [7:0]  b_m_tdata;
  logic [1:0]  b_rd_addr;
  logic [7:0]  b_rd_data;
  logic        b_done, b_es, b_el;

  logic [31:0] a_scene [16];
  logic [7:0]  b_scene [3];

  raytracer_axis_stream u_a (
    .aclk          (clk),
    .areset        (rst),
    .s_axis_tready (a_s_tready),
    .s_axis_tdata  (a_s_tdata),
    .s_axis_tlast  (a_s_tlast),
    .s_axis_tvalid (a_s_tvalid),
    .m_axis_tvalid (a_m_tvalid),
    .m_axis_tdata  (a_m_tdata),
    .m_axis_tlast  (a_m_tlast),
    .m_axis_tready (a_m_tready),
    .scene_rd_addr (a_rd_addr),
    .scene_rd_data (a_rd_data),
    .frame_done    (a_done),
    .err_short     (a_es),
    .err_long      (a_el)
  );

  raytracer_axis_stream #(
    .DataWidth        (8),
    .ScenePayloadSize (3),
    .FragmentSize     (8),
    .NumFragments     (4),
    .DummyData        (64'hF0),
    .TlastPerFragment (1'b0)
  ) u_b (
    .aclk          (clk),
    .areset        (rst),
    .s_axis_tready (b_s_tready),
    .s_axis_tdata  (b_s_tdata),
    .s_axis_tlast  (b_s_tlast),
    .s_axis_tvalid (b_s_tvalid),
    .m_axis_tvalid (b_m_tvalid),
    .m_axis_tdata  (b_m_tdata),
    .m_axis_tlast  (b_m_tlast),
    .m_axis_tready (b_m_tready),
    .scene_rd_addr (b_rd_addr),
    .scene_rd_data (b_rd_data),
    .frame_done    (b_done),
    .err_short     (b_es),
    .err_long      (b_el)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse/occupancy counters sampled away from the active edge.
  int a_es_n = 0, a_el_n = 0, a_done_n = 0;
  int a_mv_n = 0, a_bad_n = 0;
  always @(negedge clk) begin
    if (a_es) a_es_n++;
    if (a_el) a_el_n++;
    if (a_done) a_done_n++;
    if (a_m_tvalid) a_mv_n++;
    if (!rst && (a_s_tready == a_m_tvalid)) a_bad_n++;
  end

  task automatic a_send(input int n, input int last_at, input bit rnd);
    logic [31:0] w[$];
    for (int i = 0; i < n; i++) begin
      int gap;
      logic [31:0] dat;
      @(negedge clk);
      if (i == 16 && last_at > 15)
        chk("err_long_pulse", a_el, 1);
      gap = rnd ? int'($urandom_range(0, 2)) : 0;
      if (gap > 0) begin
        a_s_tvalid = 1'b0;
        repeat (gap) @(negedge clk);
      end
      dat = rnd ? $urandom : 32'(i);
      a_s_tdata  = dat;
      a_s_tlast  = (i == last_at);
      a_s_tvalid = 1'b1;
      w.push_back(dat);
      @(posedge clk);
    end
    if (n == 16 && last_at == 15)
      for (int i = 0; i < 16; i++) a_scene[i] = w[i];
  endtask

  task automatic a_collect(input int mode, input int rst_at);
    logic [31:0] ed[$];
    bit          el[$];
    int idx = 0;
    int cyc = 0;
    int fd0;
    for (int f = 0; f < 4; f++)
      for (int w = 0; w < 64; w++) begin
        ed.push_back(32'hDEAD_0000 + 32'(f * 64 + w));
        el.push_back(w == 63);
      end
    fd0 = a_done_n;
    @(negedge clk);
    a_s_tvalid = 1'b0;
    a_s_tlast  = 1'b0;
    chk("first_valid", a_m_tvalid, 1);
    while (idx < 256) begin
      if (cyc > 3000) begin
        chk("emit_timeout", idx, 256);
        break;
      end
      case (mode)
        0: a_m_tready = 1'b1;
        1: a_m_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: a_m_tready = 1'($urandom_range(0, 1));
      endcase
      chk("m_tvalid", a_m_tvalid, 1);
      chk("m_tdata", a_m_tdata, ed[idx]);
      chk("m_tlast", a_m_tlast, el[idx]);
      if (idx == rst_at) begin
        #2 rst = 1'b1;
        #1;
        chk("rst_mvalid", a_m_tvalid, 0);
        chk("rst_sready", a_s_tready, 0);
        chk("rst_tdata", a_m_tdata, 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rel_sready", a_s_tready, 1);
        chk("rel_mvalid", a_m_tvalid, 0);
        a_m_tready = 1'b0;
        return;
      end
      if (a_m_tready) idx++;
      cyc++;
      @(negedge clk);
    end
    chk("frame_done", a_done, 1);
    chk("done_sready", a_s_tready, 1);
    chk("done_mvalid", a_m_tvalid, 0);
    a_m_tready = 1'b0;
    @(negedge clk);
    chk("done_once", a_done_n - fd0, 1);
  endtask

  task automatic a_rb(input int addr);
    a_rd_addr = 4'(addr);
    #1;
    chk("scene_rd", a_rd_data, a_scene[addr]);
  endtask

  task automatic b_run();
    int idx = 0;
    int cyc = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      b_scene[i] = 8'($urandom);
      b_s_tdata  = b_scene[i];
      b_s_tlast  = (i == 2);
      b_s_tvalid = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    b_s_tvalid = 1'b0;
    b_s_tlast  = 1'b0;
    while (idx < 32 && cyc < 500) begin
      logic [7:0] ed;
      ed = 8'(32'hF0 + 32'(idx));
      b_m_tready = 1'($urandom_range(0, 1));
      chk("b_tvalid", b_m_tvalid, 1);
      chk("b_tdata", b_m_tdata, ed);
      chk("b_tlast", b_m_tlast, idx == 31);
      if (b_m_tready) idx++;
      cyc++;
      @(negedge clk);
    end
    chk("b_count", idx, 32);
    chk("b_done", b_done, 1);
    b_m_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b_rd_addr = 2'(i);
      #1;
      chk("b_scene_rd", b_rd_data, b_scene[i]);
    end
    b_rd_addr = 2'd3;
    #1;
    chk("b_rd_oob", b_rd_data, 0);
  endtask

  initial begin
    int es0, el0, mv0;
    a_s_tvalid = 0; a_s_tlast = 0; a_s_tdata = '0;
    a_m_tready = 0; a_rd_addr = '0;
    b_s_tvalid = 0; b_s_tlast = 0; b_s_tdata = '0;
    b_m_tready = 0; b_rd_addr = '0;

    @(negedge clk);
    chk("rst_sready0", a_s_tready, 0);
    chk("rst_mvalid0", a_m_tvalid, 0);
    chk("rst_tdata0", a_m_tdata, 0);
    chk("rst_tlast0", a_m_tlast, 0);
    chk("rst_flags0", {a_done, a_es, a_el}, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rel_sready0", a_s_tready, 1);
    chk("rel_b_sready0", b_s_tready, 1);

    a_send(16, 15, 1'b0);
    a_collect(0, -1);
    a_rb(5);
    a_rb(15);

    a_send(16, 15, 1'b0);
    a_collect(1, -1);

    es0 = a_es_n; el0 = a_el_n; mv0 = a_mv_n;
    a_send(8, 7, 1'b1);
    @(negedge clk);
    a_s_tvalid = 1'b0;
    a_s_tlast  = 1'b0;
    chk("err_short", a_es, 1);
    repeat (3) @(negedge clk);
    chk("err_short_once", a_es_n - es0, 1);
    chk("short_no_out", a_mv_n - mv0, 0);
    chk("short_sready", a_s_tready, 1);
    a_send(16, 15, 1'b1);
    a_collect(2, -1);
    for (int i = 0; i < 4; i++) a_rb(int'($urandom_range(0, 15)));

    es0 = a_es_n; el0 = a_el_n; mv0 = a_mv_n;
    a_send(20, 19, 1'b1);
    @(negedge clk);
    a_s_tvalid = 1'b0;
    a_s_tlast  = 1'b0;
    repeat (2) @(negedge clk);
    chk("err_long_once", a_el_n - el0, 1);
    chk("long_no_short", a_es_n - es0, 0);
    chk("long_no_out", a_mv_n - mv0, 0);
    a_send(16, 15, 1'b1);
    a_collect(2, -1);
    a_rb(3);

    b_run();

    a_send(16, 15, 1'b1);
    a_collect(0, 10);
    a_send(16, 15, 1'b1);
    a_collect(2, -1);
    a_rb(0);
    a_rb(9);

    chk("handshake_excl", a_bad_n, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
